mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Parametrised multi-cycle controller for the MIPS32 datapath. It sequences Fetch, Decode, Execute, Memory and Write-back with a variable number of states per instruction class. It waits on ready/acknowledge handshakes from instruction and data memory, with a bounded-wait timeout. It also retires an instruction counter and flags illegal opcodes. It sits between the decoder (supplies decdOp) and the datapath (PC, IR, GPR, ALU, DM).

Parameters:
TIMEOUT, 16, max cycles to wait for im_ack/dm_ack before entering Err; 0 disables the timeout.
TO_W, 5, width of the wait counter; must hold TIMEOUT.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  synchronous active-high reset
decdOp  in  7  decoded opcode, valid from Decd onward
zero  in  1  ALU zero flag, valid in Exe
im_ack  in  1  instruction memory data ready
dm_ack  in  1  data memory access done
im_req  out  1  instruction fetch request
dm_req  out  1  data memory request
IRWr  out  1  IR load strobe
PCWr  out  1  PC write enable
GPRWr  out  1  register file write enable
DMWr  out  1  data memory write enable
ExtOp  out  1  1 = sign-extend immediate
RWSel  out  1  1 = rd is destination, 0 = rt
BSel  out  1  1 = ALU B is immediate
MemToReg  out  1  0 = write-back from DM, 1 = from ALU
nPCOp  out  2  00 = PC+4, 01 = branch, 10 = jump
ALUOp  out  4  0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 sll, 7 lui
state  out  3  current FSM state
start  out  1  one-cycle pulse on the first Fetch after reset
ill  out  1  one-cycle pulse on an illegal opcode
err  out  1  sticky handshake timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- Opcodes:
  - addu 1000011, subu 1000111, slt 1010011: R-type, RWSel=1, BSel=0.
  - ori 0011010: ExtOp=1.
  - lui 0011111: ExtOp=0, ALUOp=7.
  - lw 1000110, sw 1010110, beq 0001000: ExtOp=1, BSel=1.
  - j 0000100.
  - ALUOp: add for addu, lw, sw; sub for subu and beq; or for ori; slt for slt; lui for lui.
  - Any other opcode is illegal.
- State encoding: Init 000, Fetch 001, Decd 010, Exe 011, OpMem 100, WrBack 101, Err 111.
- On clr:
  - state=Init, wait counter=0, retired=0, err=0, ill=0, start=0.
  - Every strobe (im_req, dm_req, IRWr, PCWr, GPRWr, DMWr) = 0.
  - clr mid-operation aborts the instruction with no further strobes.
- Init: go to Fetch next cycle; start=1 for that single Fetch cycle only.
- Fetch:
  - im_req=1.
  - On im_ack: IRWr=1, PCWr=1, nPCOp=00; next state Decd.
  - Otherwise stay and increment the wait counter.
- Decd: next state Exe. If the opcode is illegal, ill=1 for one cycle and next state is Fetch (treated as nop, not retired).
- Exe:
  - R-type, ori, lui: next WrBack.
  - lw, sw: next OpMem.
  - beq: PCWr=zero, nPCOp=01; next Fetch; retire.
  - j: PCWr=1, nPCOp=10; next Fetch; retire.
- OpMem:
  - dm_req=1; DMWr=1 only for sw, held while waiting.
  - On dm_ack: lw goes to WrBack; sw goes to Fetch and retires.
  - Otherwise stay and count.
- WrBack: GPRWr=1 for exactly one cycle; MemToReg=0 for lw, 1 otherwise; next Fetch; retire.
- Strobes are combinational from state, decdOp, zero and the acks. Each write strobe is high for at most one cycle per instruction.
- Wait counter:
  - Clears on every state change.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack, go to Err.
- Err: err=1, all strobes 0, held until clr.
- retired increments by 1 per completed instruction and wraps modulo 2^CNT_W.
- Cycle counts with zero-wait acks: R/ori/lui 4, lw 5, sw 4, beq/j 3.

Test Plan:
- clr held 2 cycles then released, im_ack=1 -> state 000→001; start=1 for one cycle; retired=0.
- addu with acks tied high -> Fetch, Decd, Exe, WrBack; GPRWr=1 only in WrBack; RWSel=1; ALUOp=1; retired=1 after 4 cycles.
- lw with dm_ack delayed 3 cycles -> OpMem lasts 4 cycles, dm_req=1, DMWr=0; then WrBack with MemToReg=0; 8 cycles total.
- beq with zero=1, then beq with zero=0 -> PCWr=1 with nPCOp=01 in Exe for the first; PCWr=0 in Exe for the second; 3 cycles each.
- decdOp=1111111 -> ill pulses once in Decd; no GPRWr or DMWr; returns to Fetch; retired unchanged.
- TIMEOUT=4, im_ack=0 -> Err after 4 Fetch cycles, err=1 sticky; clr recovers to Init with err=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the MIPS32 datapath.
// The master side is the controller; the slave side is the datapath or the memories.
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic [6:0]       decdOp;
    logic             zero;
    logic             im_ack;
    logic             dm_ack;
    logic             im_req;
    logic             dm_req;
    logic             IRWr;
    logic             PCWr;
    logic             GPRWr;
    logic             DMWr;
    logic             ExtOp;
    logic             RWSel;
    logic             BSel;
    logic             MemToReg;
    logic [1:0]       nPCOp;
    logic [3:0]       ALUOp;
    logic [2:0]       state;
    logic             start;
    logic             ill;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  decdOp, zero, im_ack, dm_ack,
        output im_req, dm_req, IRWr, PCWr, GPRWr, DMWr,
               ExtOp, RWSel, BSel, MemToReg, nPCOp, ALUOp,
               state, start, ill, err, retired
    );

    modport slave (
        output decdOp, zero, im_ack, dm_ack,
        input  im_req, dm_req, IRWr, PCWr, GPRWr, DMWr,
               ExtOp, RWSel, BSel, MemToReg, nPCOp, ALUOp,
               state, start, ill, err, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS32 controller: Fetch/Decode/Execute/Memory/Write-back sequencing with
// bounded-wait memory handshakes, illegal-opcode flagging and a retired-instruction counter.
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic      clk,
    input  logic      clr,
    mc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_INIT   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECD   = 3'b010,
        S_EXE    = 3'b011,
        S_OPMEM  = 3'b100,
        S_WRBACK = 3'b101,
        S_ERR    = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL
    } kind_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] retired;
    logic             start;

    kind_t            kind;
    logic             ext_op;
    logic             rw_sel;
    logic             b_sel;
    logic [3:0]       alu_op;

    logic             im_req;
    logic             dm_req;
    logic             ir_wr;
    logic             pc_wr;
    logic             gpr_wr;
    logic             dm_wr;
    logic             ill;
    logic [1:0]       npc_op;
    logic             retire;
    logic             wait_inc;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

    // Opcode decode into instruction class and datapath selects.
    always_comb begin
        kind   = K_ILL;
        ext_op = 1'b0;
        rw_sel = 1'b0;
        b_sel  = 1'b0;
        alu_op = 4'd0;
        unique case (bus.decdOp)
            7'b1000011: begin kind = K_R;   rw_sel = 1'b1; alu_op = 4'd1; end
            7'b1000111: begin kind = K_R;   rw_sel = 1'b1; alu_op = 4'd2; end
            7'b1010011: begin kind = K_R;   rw_sel = 1'b1; alu_op = 4'd5; end
            7'b0011010: begin kind = K_ORI; ext_op = 1'b1; b_sel = 1'b1; alu_op = 4'd4; end
            7'b0011111: begin kind = K_LUI; b_sel = 1'b1; alu_op = 4'd7; end
            7'b1000110: begin kind = K_LW;  ext_op = 1'b1; b_sel = 1'b1; alu_op = 4'd1; end
            7'b1010110: begin kind = K_SW;  ext_op = 1'b1; b_sel = 1'b1; alu_op = 4'd1; end
            7'b0001000: begin kind = K_BEQ; ext_op = 1'b1; b_sel = 1'b1; alu_op = 4'd2; end
            7'b0000100: begin kind = K_J; end
            default:    kind = K_ILL;
        endcase
    end

    // Next-state and strobe logic.
    always_comb begin
        state_nxt = state;
        im_req    = 1'b0;
        dm_req    = 1'b0;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        gpr_wr    = 1'b0;
        dm_wr     = 1'b0;
        ill       = 1'b0;
        npc_op    = 2'b00;
        retire    = 1'b0;
        wait_inc  = 1'b0;
        unique case (state)
            S_INIT: state_nxt = S_FETCH;
            S_FETCH: begin
                im_req = 1'b1;
                if (bus.im_ack) begin
                    ir_wr     = 1'b1;
                    pc_wr     = 1'b1;
                    state_nxt = S_DECD;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECD: begin
                if (kind == K_ILL) begin
                    ill       = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                unique case (kind)
                    K_R, K_ORI, K_LUI: state_nxt = S_WRBACK;
                    K_LW, K_SW:        state_nxt = S_OPMEM;
                    K_BEQ: begin
                        pc_wr     = bus.zero;
                        npc_op    = 2'b01;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    K_J: begin
                        pc_wr     = 1'b1;
                        npc_op    = 2'b10;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_OPMEM: begin
                dm_req = 1'b1;
                dm_wr  = (kind == K_SW);
                if (bus.dm_ack) begin
                    if (kind == K_SW) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WRBACK;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WRBACK: begin
                gpr_wr    = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_INIT;
        endcase
        // A clear in flight silences everything so an aborted instruction leaves no trace.
        if (clr) begin
            im_req = 1'b0;
            dm_req = 1'b0;
            ir_wr  = 1'b0;
            pc_wr  = 1'b0;
            gpr_wr = 1'b0;
            dm_wr  = 1'b0;
            ill    = 1'b0;
            retire = 1'b0;
        end
    end

    // State, wait counter, start pulse and retired counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_INIT;
            wait_cnt <= '0;
            retired  <= '0;
            start    <= 1'b0;
        end else begin
            state <= state_nxt;
            start <= (state == S_INIT);
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign bus.im_req   = im_req;
    assign bus.dm_req   = dm_req;
    assign bus.IRWr     = ir_wr;
    assign bus.PCWr     = pc_wr;
    assign bus.GPRWr    = gpr_wr;
    assign bus.DMWr     = dm_wr;
    assign bus.ExtOp    = ext_op;
    assign bus.RWSel    = rw_sel;
    assign bus.BSel     = b_sel;
    assign bus.MemToReg = (kind != K_LW);
    assign bus.nPCOp    = npc_op;
    assign bus.ALUOp    = alu_op;
    assign bus.state    = state;
    assign bus.start    = start;
    assign bus.ill      = ill;
    assign bus.err      = (state == S_ERR);
    assign bus.retired  = retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle sequences are built
// from the instruction-class timing rules, then replayed against the DUT cycle by cycle.
module tb_mc_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 32;

    localparam int K_R = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;

    localparam logic [2:0] ST_INIT = 3'b000, ST_FETCH = 3'b001, ST_DECD = 3'b010,
                           ST_EXE = 3'b011, ST_OPMEM = 3'b100, ST_WB = 3'b101, ST_ERR = 3'b111;

    localparam logic [6:0] OP_ADDU = 7'b1000011, OP_SUBU = 7'b1000111, OP_SLT = 7'b1010011,
                           OP_ORI = 7'b0011010, OP_LUI = 7'b0011111, OP_LW = 7'b1000110,
                           OP_SW = 7'b1010110, OP_BEQ = 7'b0001000, OP_J = 7'b0000100;

    typedef struct {
        logic [2:0] st;
        logic [6:0] op;
        bit         ima, dma, zv;
        bit         imr, dmr, irw, pcw, gw, dw, il, strt, ret;
        bit         npc_chk;
        logic [1:0] npc;
        bit         fld_chk, m2r_chk;
    } cyc_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    cyc_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc_no   = 0;
    int unsigned model_ret = 0;
    bit          first_fetch = 1'b0;
    logic [6:0]  ops [0:8] = '{OP_ADDU, OP_SUBU, OP_SLT, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            OP_ADDU, OP_SUBU, OP_SLT: return K_R;
            OP_ORI:  return K_ORI;
            OP_LUI:  return K_LUI;
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_BEQ:  return K_BEQ;
            OP_J:    return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [6:0] op);
        case (op)
            OP_ADDU, OP_LW, OP_SW: return 4'd1;
            OP_SUBU, OP_BEQ:       return 4'd2;
            OP_ORI:                return 4'd4;
            OP_SLT:                return 4'd5;
            OP_LUI:                return 4'd7;
            default:               return 4'd0;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [2:0] st, input logic [6:0] op, input bit zv);
        cyc_t c;
        c.st = st;   c.op = op;   c.zv = zv;
        c.ima = bit'($urandom_range(0, 1));
        c.dma = bit'($urandom_range(0, 1));
        c.imr = 0; c.dmr = 0; c.irw = 0; c.pcw = 0; c.gw = 0; c.dw = 0;
        c.il = 0;  c.strt = 0; c.ret = 0;
        c.npc_chk = 0; c.npc = 2'b00; c.fld_chk = 0; c.m2r_chk = 0;
        return c;
    endfunction

    function automatic void push(input cyc_t c_in);
        cyc_t c = c_in;
        if (first_fetch) begin
            c.strt      = 1'b1;
            first_fetch = 1'b0;
        end
        q.push_back(c);
    endfunction

    // Expected cycle sequence of one instruction; imd/dmd are no-ack cycles before the ack.
    function automatic void build(input logic [6:0] op, input bit zv, input int imd, input int dmd);
        int   k = kind_of(op);
        cyc_t c;
        for (int i = 0; i < imd && i < int'(TIMEOUT); i++) begin
            c = blank(ST_FETCH, 7'($urandom), zv);
            c.ima = 0; c.imr = 1;
            push(c);
        end
        if (imd >= int'(TIMEOUT)) return;
        c = blank(ST_FETCH, 7'($urandom), zv);
        c.ima = 1; c.imr = 1; c.irw = 1; c.pcw = 1; c.npc_chk = 1; c.npc = 2'b00;
        push(c);
        c = blank(ST_DECD, op, zv);
        c.il = (k == K_ILL);
        push(c);
        if (k == K_ILL) return;
        c = blank(ST_EXE, op, zv);
        c.fld_chk = 1;
        if (k == K_BEQ) begin c.pcw = zv;   c.npc_chk = 1; c.npc = 2'b01; c.ret = 1; end
        if (k == K_J)   begin c.pcw = 1'b1; c.npc_chk = 1; c.npc = 2'b10; c.ret = 1; end
        push(c);
        if (k == K_BEQ || k == K_J) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < dmd && i < int'(TIMEOUT); i++) begin
                c = blank(ST_OPMEM, op, zv);
                c.dma = 0; c.dmr = 1; c.dw = (k == K_SW);
                push(c);
            end
            if (dmd >= int'(TIMEOUT)) return;
            c = blank(ST_OPMEM, op, zv);
            c.dma = 1; c.dmr = 1; c.dw = (k == K_SW); c.ret = (k == K_SW);
            push(c);
            if (k == K_SW) return;
        end
        c = blank(ST_WB, op, zv);
        c.gw = 1; c.ret = 1; c.m2r_chk = 1;
        push(c);
    endfunction

    function automatic string tg(input string s);
        return $sformatf("c%0d_%s", cyc_no, s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk(tg({pfx, "_im_req"}), 32'(bus.im_req), 32'(0));
        chk(tg({pfx, "_dm_req"}), 32'(bus.dm_req), 32'(0));
        chk(tg({pfx, "_IRWr"}),   32'(bus.IRWr),   32'(0));
        chk(tg({pfx, "_PCWr"}),   32'(bus.PCWr),   32'(0));
        chk(tg({pfx, "_GPRWr"}),  32'(bus.GPRWr),  32'(0));
        chk(tg({pfx, "_DMWr"}),   32'(bus.DMWr),   32'(0));
        chk(tg({pfx, "_ill"}),    32'(bus.ill),    32'(0));
    endtask

    task automatic step_check(input cyc_t c);
        int k = kind_of(c.op);
        @(posedge clk); #1;
        cyc_no++;
        bus.im_ack = c.ima; bus.dm_ack = c.dma; bus.decdOp = c.op; bus.zero = c.zv;
        #1;
        chk(tg("state"),   32'(bus.state),   32'(c.st));
        chk(tg("im_req"),  32'(bus.im_req),  32'(c.imr));
        chk(tg("dm_req"),  32'(bus.dm_req),  32'(c.dmr));
        chk(tg("IRWr"),    32'(bus.IRWr),    32'(c.irw));
        chk(tg("PCWr"),    32'(bus.PCWr),    32'(c.pcw));
        chk(tg("GPRWr"),   32'(bus.GPRWr),   32'(c.gw));
        chk(tg("DMWr"),    32'(bus.DMWr),    32'(c.dw));
        chk(tg("ill"),     32'(bus.ill),     32'(c.il));
        chk(tg("start"),   32'(bus.start),   32'(c.strt));
        chk(tg("err"),     32'(bus.err),     32'(0));
        chk(tg("retired"), 32'(bus.retired), 32'(model_ret));
        if (c.npc_chk) chk(tg("nPCOp"), 32'(bus.nPCOp), 32'(c.npc));
        if (c.fld_chk) begin
            chk(tg("ALUOp"), 32'(bus.ALUOp), 32'(alu_of(c.op)));
            case (k)
                K_R: begin
                    chk(tg("RWSel"), 32'(bus.RWSel), 32'(1));
                    chk(tg("BSel"),  32'(bus.BSel),  32'(0));
                end
                K_LW, K_SW, K_BEQ: begin
                    chk(tg("ExtOp"), 32'(bus.ExtOp), 32'(1));
                    chk(tg("BSel"),  32'(bus.BSel),  32'(1));
                end
                K_ORI:   chk(tg("ExtOp"), 32'(bus.ExtOp), 32'(1));
                K_LUI:   chk(tg("ExtOp"), 32'(bus.ExtOp), 32'(0));
                default: ;
            endcase
        end
        if (c.m2r_chk) chk(tg("MemToReg"), 32'(bus.MemToReg), 32'((k == K_LW) ? 0 : 1));
        if (c.ret) model_ret++;
    endtask

    task automatic run_q();
        while (q.size() > 0) step_check(q.pop_front());
    endtask

    task automatic run_partial(input int n);
        for (int j = 0; j < n && q.size() > 0; j++) step_check(q.pop_front());
        q.delete();
    endtask

    // Two clr cycles with acks high, then one released cycle still in Init.
    task automatic do_reset();
        @(posedge clk); #1;
        cyc_no++;
        clr = 1'b1; bus.im_ack = 1'b1; bus.dm_ack = 1'b1; bus.zero = bit'($urandom_range(0, 1));
        #1;
        chk_quiet("clr1");
        @(posedge clk); #2;
        cyc_no++;
        chk(tg("clr_state"),   32'(bus.state),   32'(ST_INIT));
        chk(tg("clr_retired"), 32'(bus.retired), 32'(0));
        chk(tg("clr_err"),     32'(bus.err),     32'(0));
        chk(tg("clr_start"),   32'(bus.start),   32'(0));
        chk_quiet("clr2");
        @(posedge clk); #1;
        cyc_no++;
        clr = 1'b0;
        #1;
        chk(tg("init_state"), 32'(bus.state), 32'(ST_INIT));
        chk(tg("init_start"), 32'(bus.start), 32'(0));
        chk_quiet("init");
        model_ret   = 0;
        first_fetch = 1'b1;
    endtask

    task automatic hold_err(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cyc_no++;
            bus.im_ack = bit'($urandom_range(0, 1));
            bus.dm_ack = bit'($urandom_range(0, 1));
            bus.decdOp = 7'($urandom);
            #1;
            chk(tg("err_state"),   32'(bus.state),   32'(ST_ERR));
            chk(tg("err_flag"),    32'(bus.err),     32'(1));
            chk(tg("err_start"),   32'(bus.start),   32'(0));
            chk(tg("err_retired"), 32'(bus.retired), 32'(model_ret));
            chk_quiet("err");
        end
    endtask

    initial begin
        logic [6:0] op;
        int         idx;
        clr = 1'b1;
        bus.decdOp = 7'd0; bus.zero = 1'b0; bus.im_ack = 1'b1; bus.dm_ack = 1'b1;
        do_reset();

        // Directed instructions covering every class and the wait boundary.
        build(OP_ADDU, 1'b0, 0, 0); run_q();
        build(OP_LW,   1'b0, 0, 3); run_q();
        build(OP_BEQ,  1'b1, 0, 0); run_q();
        build(OP_BEQ,  1'b0, 0, 0); run_q();
        build(7'b1111111, 1'b0, 0, 0); run_q();
        build(OP_J,    1'b0, 1, 0); run_q();
        build(OP_SW,   1'b0, 0, 2); run_q();
        build(OP_ORI,  1'b0, 0, 0); run_q();
        build(OP_LUI,  1'b1, 0, 0); run_q();
        build(OP_SUBU, 1'b0, 2, 0); run_q();
        build(OP_SLT,  1'b0, 3, 0); run_q();

        // Randomized instruction stream with occasional clr mid-instruction.
        for (int i = 0; i < 250; i++) begin
            idx = int'($urandom_range(0, 9));
            if (idx == 9) op = 7'($urandom);
            else          op = ops[idx];
            build(op, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 11) == 0) begin
                run_partial(int'($urandom_range(1, q.size())));
                do_reset();
            end else begin
                run_q();
            end
        end

        // Fetch timeout, sticky err, recovery.
        build(OP_ADDU, 1'b0, int'(TIMEOUT) + int'($urandom_range(0, 2)), 0); run_q();
        hold_err(3);
        do_reset();
        build(OP_ADDU, 1'b0, 0, 0); run_q();

        // Data-memory timeout while a store is pending.
        build(OP_SW, 1'b0, 0, int'(TIMEOUT) + 1); run_q();
        hold_err(2);
        do_reset();
        build(OP_LW, 1'b0, 1, 1); run_q();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
